// File: rtl/shift_chain_output_if.sv
// Frame handshake and 74HC595 pin bundle for shift_chain_output.
// SHIFT_CHAIN_DEBUG_EN adds the o_latched_value mirror of the displayed frame.
interface shift_chain_output_if #(
    parameter int W = 16
);
    logic [W-1:0] i_value;
    logic         i_valid;
    logic         o_ready;
    logic         o_data_val;
    logic         o_data_clock;
    logic         o_latch_shifted_value;
    logic         o_busy;
    logic         o_done;
`ifdef SHIFT_CHAIN_DEBUG_EN
    logic [W-1:0] o_latched_value;

    modport master (
        output i_value, i_valid,
        input  o_ready, o_data_val, o_data_clock,
        input  o_latch_shifted_value, o_busy, o_done,
        input  o_latched_value
    );

    modport slave (
        input  i_value, i_valid,
        output o_ready, o_data_val, o_data_clock,
        output o_latch_shifted_value, o_busy, o_done,
        output o_latched_value
    );
`else
    modport master (
        output i_value, i_valid,
        input  o_ready, o_data_val, o_data_clock,
        input  o_latch_shifted_value, o_busy, o_done
    );

    modport slave (
        input  i_value, i_valid,
        output o_ready, o_data_val, o_data_clock,
        output o_latch_shifted_value, o_busy, o_done
    );
`endif
endinterface

// File: rtl/shift_chain_output.sv
// Serialises a W-bit frame into a chain of 74HC595 registers, then pulses the latch.
// Optional macro SHIFT_CHAIN_DEBUG_EN adds o_latched_value (frame currently displayed).
module shift_chain_output #(
    parameter int NUM_REGS    = 2,
    parameter int CLK_DIV     = 4,
    parameter int LATCH_WIDTH = 2
) (
    input logic i_clk,
    input logic i_reset,
    shift_chain_output_if.slave bus
);
    localparam int W   = 8 * NUM_REGS;
    localparam int BW  = (W > 1) ? $clog2(W) : 1;
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LTW = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic [DW-1:0]  div_q, div_d;
    logic [LTW-1:0] lat_q, lat_d;
    logic           lead_q, lead_d;
    logic           data_q, data_d;
    logic           dclk_q, dclk_d;
    logic           latch_q, latch_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic div_last, bit_last, lat_last;

    assign div_last = (div_q == DW'(CLK_DIV - 1));
    assign bit_last = (bit_q == BW'(W - 1));
    assign lat_last = (lat_q == LTW'(LATCH_WIDTH - 1));

    // Outputs are registered alongside the state; the first LOW phase
    // carries one extra lead cycle so data is set up before the first rise.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        lat_d   = lat_q;
        lead_d  = lead_q;
        data_d  = data_q;
        dclk_d  = dclk_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    state_d = LOW;
                    shreg_d = bus.i_value;
                    bit_d   = '0;
                    div_d   = '0;
                    lead_d  = 1'b1;
                    busy_d  = 1'b1;
                    data_d  = bus.i_value[W-1];
                end
            end
            LOW: begin
                if (lead_q) begin
                    lead_d = 1'b0;
                end else if (div_last) begin
                    div_d   = '0;
                    state_d = HIGH;
                    dclk_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    dclk_d  = 1'b0;
                    if (bit_last) begin
                        state_d = LATCH;
                        data_d  = 1'b0;
                        latch_d = 1'b1;
                        lat_d   = '0;
                    end else begin
                        state_d = LOW;
                        bit_d   = bit_q + 1'b1;
                        data_d  = shreg_q[W-2];
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (lat_last) begin
                    state_d = IDLE;
                    latch_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            lat_q   <= '0;
            lead_q  <= 1'b0;
            data_q  <= 1'b0;
            dclk_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            lat_q   <= lat_d;
            lead_q  <= lead_d;
            data_q  <= data_d;
            dclk_q  <= dclk_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_ready               = (state_q == IDLE);
    assign bus.o_data_val            = data_q;
    assign bus.o_data_clock          = dclk_q;
    assign bus.o_latch_shifted_value = latch_q;
    assign bus.o_busy                = busy_q;
    assign bus.o_done                = done_q;

`ifdef SHIFT_CHAIN_DEBUG_EN
    logic [W-1:0] frame_q;
    logic [W-1:0] shown_q;

    // shreg is consumed by shifting, so the accepted frame is kept separately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            frame_q <= '0;
            shown_q <= '0;
        end else begin
            if (state_q == IDLE && bus.i_valid)
                frame_q <= bus.i_value;
            if (state_q == HIGH && div_last && bit_last)
                shown_q <= frame_q;
        end
    end

    assign bus.o_latched_value = shown_q;
`endif
endmodule

// File: tb/tb_shift_chain_output.sv
// Self-checking bench for shift_chain_output with a 595-chain reference model.
module tb_shift_chain_output;
    localparam int NUM_REGS    = 2;
    localparam int CLK_DIV     = 4;
    localparam int LATCH_WIDTH = 2;
    localparam int W  = 8 * NUM_REGS;
    localparam int C  = CLK_DIV;
    localparam int LW = LATCH_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;

    shift_chain_output_if #(.W(W)) bus ();

    shift_chain_output #(
        .NUM_REGS(NUM_REGS),
        .CLK_DIV(CLK_DIV),
        .LATCH_WIDTH(LATCH_WIDTH)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [W-1:0] v, input bit hold,
                         output int acc);
        bus.i_value = v;
        bus.i_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        bus.i_valid = hold;
    endtask

    // Follows one frame from its accept edge, feeding every observed
    // rising shift clock into an ideal 595 chain.
    task automatic watch(input int acc, input logic [W-1:0] v,
                         input bit spam, input string tag, output int dn);
        int rises = 0, first = -1, lrise = -1, lfall = -1, pulses = 0;
        int badh = 0, bads = 0, rdy = 0, e;
        int last_chg = acc, last_rise = acc;
        logic pc = 1'b0, pd = 1'b0, pl = 1'b0;
        logic [W-1:0] chain = '0, disp = '0;
        dn = -1;
        for (int n = 0; n < 2*C*W + LW + 20 && dn < 0; n++) begin
            e = cyc;
            if (bus.o_data_val !== pd) begin
                last_chg = e;
                if (bus.o_data_clock) badh++;
            end
            if (bus.o_data_clock && !pc) begin
                rises++;
                last_rise = e;
                if (first < 0) first = e;
                if (e - last_chg < C) bads++;
                chain = {chain[W-2:0], bus.o_data_val};
            end
            if (!bus.o_data_clock && pc && e - last_rise != C) bads++;
            if (bus.o_latch_shifted_value && !pl) begin
                pulses++;
                lrise = e;
                disp = chain;
`ifdef SHIFT_CHAIN_DEBUG_EN
                chk({tag, "_dbg"}, 64'(bus.o_latched_value), 64'(v));
`endif
            end
            if (!bus.o_latch_shifted_value && pl) lfall = e;
            if (bus.o_done) dn = e;
            else if (bus.o_ready) rdy++;
            if (spam) begin
                bus.i_valid = (n == 5);
                bus.i_value = (n == 5) ? '1 : v;
            end
            pc = bus.o_data_clock;
            pd = bus.o_data_val;
            pl = bus.o_latch_shifted_value;
            if (dn < 0) @(negedge clk);
        end
        chk({tag, "_rises"}, 64'(rises), 64'(W));
        chk({tag, "_first_rise"}, 64'(first), 64'(acc + 1 + C));
        chk({tag, "_latch_rise"}, 64'(lrise), 64'(acc + 1 + 2*C*W));
        chk({tag, "_latch_fall"}, 64'(lfall), 64'(acc + 1 + 2*C*W + LW));
        chk({tag, "_done"}, 64'(dn), 64'(acc + 1 + 2*C*W + LW));
        chk({tag, "_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_far"}, 64'(disp[W-1:W-8]), 64'(v[W-1:W-8]));
        chk({tag, "_near"}, 64'(disp[7:0]), 64'(v[7:0]));
        chk({tag, "_hold"}, 64'(badh), 64'd0);
        chk({tag, "_setup"}, 64'(bads), 64'd0);
        chk({tag, "_ready_low"}, 64'(rdy), 64'd0);
    endtask

    initial begin
        int acc, dn, dn1, rises, lat;
        logic prev;
        logic [W-1:0] v;
        bus.i_valid = 1'b0;
        bus.i_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_data", 64'(bus.o_data_val), 64'd0);
        chk("rst_sclk", 64'(bus.o_data_clock), 64'd0);
        chk("rst_latch", 64'(bus.o_latch_shifted_value), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        start(16'h3F06, 1'b0, acc);
        chk("f3f06_busy", 64'(bus.o_busy), 64'd1);
        watch(acc, 16'h3F06, 1'b0, "f3f06", dn);

        repeat (4) begin
            v = W'($urandom);
            start(v, 1'b0, acc);
            watch(acc, v, 1'b0, "rnd", dn);
            @(negedge clk);
        end

        start(16'h0001, 1'b1, acc);
        watch(acc, 16'h0001, 1'b0, "b2b1", dn1);
        bus.i_value = 16'h8000;
        @(negedge clk);
        acc = cyc;
        bus.i_valid = 1'b0;
        chk("b2b_gap", 64'(acc), 64'(dn1 + 1));
        chk("b2b_busy", 64'(bus.o_busy), 64'd1);
        watch(acc, 16'h8000, 1'b0, "b2b2", dn);

        start(16'h00F0, 1'b0, acc);
        watch(acc, 16'h00F0, 1'b1, "spam", dn);
        bus.i_valid = 1'b0;

        start(16'h5A5A, 1'b0, acc);
        rises = 0;
        prev = 1'b0;
        for (int n = 0; n < 400 && rises < 5; n++) begin
            @(negedge clk);
            if (bus.o_data_clock && !prev) rises++;
            prev = bus.o_data_clock;
        end
        chk("abort_rises", 64'(rises), 64'd5);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 64'(bus.o_ready), 64'd1);
        chk("abort_data", 64'(bus.o_data_val), 64'd0);
        chk("abort_sclk", 64'(bus.o_data_clock), 64'd0);
        chk("abort_latch", 64'(bus.o_latch_shifted_value), 64'd0);
        chk("abort_busy", 64'(bus.o_busy), 64'd0);
        lat = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_latch_shifted_value) lat++;
        end
        chk("abort_no_latch", 64'(lat), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        start(16'h1234, 1'b0, acc);
        watch(acc, 16'h1234, 1'b0, "post_rst", dn);

`ifdef SHIFT_CHAIN_DEBUG_EN
        @(negedge clk);
        start(16'hBEEF, 1'b0, acc);
        watch(acc, 16'hBEEF, 1'b0, "beef", dn);
        chk("dbg_hold", 64'(bus.o_latched_value), 64'hBEEF);
        #2 rst = 1'b1;
        #1;
        chk("dbg_rst", 64'(bus.o_latched_value), 64'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
